key_bounce_gen: RTL and testbench
=================================

KEY_BOUNCE_GEN -- requirements
Module: key_bounce_gen

Synthesizable bouncy-key emulator. It drives the bounce-laden level that a key debouncer receives, for on-board self-test and bench stimulus.

Interface
REQ-001 The block SHALL have parameter BOUNCE_CNT, default 6: number of bounce pairs (low/high glitches) per transition, range 0..15.
REQ-002 The block SHALL have parameter BOUNCE_TICKS, default 35: clk cycles per bounce phase, at least 1.
REQ-003 The block SHALL have parameter HOLD_TICKS, default 3060: stable clk cycles after the last bounce before completion, at least 1.
REQ-004 The block SHALL have parameter LFSR_SEED, default 16'hACE1: nonzero LFSR seed, used only when randomization is compiled in.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port req_valid, input, 1 bit: a transition request is present.
REQ-008 The block SHALL have port req_level, input, 1 bit: target key level.
REQ-009 The block SHALL have port req_ready, output, 1 bit: high only in IDLE.
REQ-010 The block SHALL have port key_out, output, 1 bit: emulated raw key level.
REQ-011 The block SHALL have port busy, output, 1 bit: equals NOT req_ready.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when a request completes.

Function
REQ-013 The state machine SHALL have three states: IDLE, BOUNCE, HOLD.
REQ-014 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; that edge is edge T, and req_level is latched as target.
REQ-015 If target differs from key_out, at edge T: key_out <= target, the phase counter loads, and the FSM goes to BOUNCE (to HOLD if BOUNCE_CNT=0).
REQ-016 In BOUNCE, key_out SHALL toggle every phase length for exactly 2*BOUNCE_CNT toggles; the last toggle leaves key_out equal to target and the FSM goes to HOLD.
REQ-017 With default timing, toggles SHALL occur at edges T+k*BOUNCE_TICKS, k=1..2*BOUNCE_CNT.
REQ-018 HOLD SHALL last HOLD_TICKS cycles with key_out stable; on exit, done=1 for one cycle and the FSM returns to IDLE on that same edge.
REQ-019 If target equals key_out at acceptance, there SHALL be no toggles and no hold; done pulses at edge T+1 and the FSM stays in or returns to IDLE.
REQ-020 While busy, req_valid SHALL be ignored; a held request is accepted at the first edge where req_ready=1.
REQ-021 Counters SHALL be sized by $clog2 of their maximum; they never wrap during an operation.

Reset
REQ-022 Asserting rst SHALL asynchronously force IDLE, key_out=0, done=0, req_ready=1, busy=0, counters=0, LFSR=LFSR_SEED; this applies at any point, including mid-bounce or mid-hold.
REQ-023 After rst deasserts, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-024 With macro KEY_BOUNCE_RAND_EN defined, each bounce phase length SHALL be 1 + (LFSR[TW-2:0]), where TW=$clog2(BOUNCE_TICKS+1).
REQ-025 In that mode, a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance once per phase load; toggle count, final level and HOLD are unchanged.
REQ-026 Without KEY_BOUNCE_RAND_EN, phase length SHALL be fixed at BOUNCE_TICKS and no LFSR logic is present.

Structure
REQ-027 Package key_sim_pkg SHALL hold the state enum (IDLE/BOUNCE/HOLD), the LFSR polynomial constant and the default seed.
REQ-028 Sub-module key_lfsr16 (clk, rst, step, seed, value) SHALL exist and be instantiated only under KEY_BOUNCE_RAND_EN.

Verification
REQ-029 Press, defaults, key_out=0, request level 1 at edge T -> key_out=1 at T, toggles at T+35..T+420 (12 toggles), key_out=1 after T+420, done at T+3480.
REQ-030 Release, key_out=1, request level 0 -> mirror of REQ-029, ending at 0, done at T+3480.
REQ-031 Same-level request (key_out=0, level 0) -> key_out never changes, done at T+1, req_ready=1 at T+1.
REQ-032 req_valid held high across a press -> exactly one acceptance until done; a second acceptance occurs at the done edge only if req_ready=1 there, else at the next edge.
REQ-033 rst asserted at T+100 of a press -> key_out=0, busy=0, done=0 immediately with no clock edge; a new request is accepted afterwards.
REQ-034 KEY_BOUNCE_RAND_EN, BOUNCE_TICKS=35 -> every phase is 1..32 cycles, 12 toggles, final level equals target, and seed 16'hACE1 reproduces the same sequence.

Source files
------------

// File: rtl/key_sim_pkg.sv
// key_sim_pkg: shared FSM states and LFSR constants for the bouncy-key emulator.
package key_sim_pkg;
    typedef enum logic [1:0] {IDLE, BOUNCE, HOLD} key_state_e;
    localparam logic [15:0] LFSR_POLY     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
endpackage

// File: rtl/key_lfsr16.sv
// key_lfsr16: 16-bit right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1), advances on step.
module key_lfsr16
    import key_sim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);
    logic [15:0] value_q, value_d;

    always_comb value_d = step ? ((value_q >> 1) ^ (value_q[0] ? LFSR_POLY : 16'h0)) : value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value_q <= seed;
        else     value_q <= value_d;
    end

    assign value = value_q;
endmodule

// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulates a bouncing key level for debouncer stimulus.
// Define KEY_BOUNCE_RAND_EN for LFSR-randomised bounce phase lengths.
module key_bounce_gen
    import key_sim_pkg::*;
#(
    parameter int          BOUNCE_CNT   = 6,
    parameter int          BOUNCE_TICKS = 35,
    parameter int          HOLD_TICKS   = 3060,
    parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic key_out,
    output logic busy,
    output logic done
);
    localparam int MAXT = BOUNCE_TICKS > HOLD_TICKS ? BOUNCE_TICKS : HOLD_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam int TGW  = BOUNCE_CNT > 0 ? $clog2(2 * BOUNCE_CNT + 1) : 1;

    if (LFSR_SEED == 16'h0 || BOUNCE_TICKS < 1 || HOLD_TICKS < 1 || BOUNCE_CNT > 15) begin : g_bad_params
        $error("key_bounce_gen: invalid parameters");
    end

    key_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, phase_m1;
    logic [TGW-1:0] tog_q, tog_d;
    logic           key_q, key_d, done_q, done_d, pend_q, pend_d;

`ifdef KEY_BOUNCE_RAND_EN
    localparam int TW = $clog2(BOUNCE_TICKS + 1);
    logic [15:0] lfsr;
    logic        step;
    // One step per phase load: entering BOUNCE or reloading a phase inside it.
    assign step = (state_d == BOUNCE) && (state_q != BOUNCE || cnt_q == '0);
    key_lfsr16 u_lfsr (.clk(clk), .rst(rst), .step(step), .seed(LFSR_SEED), .value(lfsr));
    assign phase_m1 = CW'(lfsr[TW-2:0]);
`else
    assign phase_m1 = CW'(BOUNCE_TICKS - 1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tog_d   = tog_q;
        key_d   = key_q;
        done_d  = 1'b0;
        pend_d  = 1'b0;
        case (state_q)
            IDLE: begin
                done_d = pend_q;
                // A same-level request completes with a done one edge later, no FSM excursion.
                if (req_valid && req_level == key_q) begin
                    pend_d = 1'b1;
                end else if (req_valid) begin
                    key_d   = req_level;
                    state_d = BOUNCE_CNT == 0 ? HOLD : BOUNCE;
                    cnt_d   = BOUNCE_CNT == 0 ? CW'(HOLD_TICKS - 1) : phase_m1;
                    tog_d   = TGW'(2 * BOUNCE_CNT);
                end
            end
            BOUNCE: begin
                if (cnt_q == '0) begin
                    key_d   = ~key_q;
                    tog_d   = tog_q - 1'b1;
                    state_d = tog_q == TGW'(1) ? HOLD : BOUNCE;
                    cnt_d   = tog_q == TGW'(1) ? CW'(HOLD_TICKS - 1) : phase_m1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                state_d = cnt_q == '0 ? IDLE : HOLD;
                done_d  = cnt_q == '0;
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tog_q   <= '0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tog_q   <= tog_d;
            key_q   <= key_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign req_ready = state_q == IDLE;
    assign busy      = ~req_ready;
    assign key_out   = key_q;
    assign done      = done_q;
endmodule

// File: tb/tb_key_bounce_gen.sv
// tb_key_bounce_gen: random requests against a timeline model of the bouncing key.
module tb_key_bounce_gen;
    localparam int BC    = 6;
    localparam int BT    = 35;
    localparam int HT    = 3060;
    localparam int TOTAL = 2 * BC * BT + HT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_valid = 1'b0;
    logic req_level = 1'b0;
    logic req_ready, key_out, busy, done;

    int n_chk = 0;
    int n_fail = 0;

    bit   active = 0;
    bit   pend = 0;
    logic ek = 1'b0;
    logic ed = 1'b0;
    logic tgt = 1'b0;
    int   t_acc = 0;
    int   cyc = 0;

    key_bounce_gen #(.BOUNCE_CNT(BC), .BOUNCE_TICKS(BT), .HOLD_TICKS(HT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_level(req_level),
        .req_ready(req_ready), .key_out(key_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
        end
    endtask

    // Expected waveform from acceptance time: key = target xor parity of toggles so far.
    task automatic model_edge(input logic v, input logic l);
        bit rdy;
        int d, k;
        cyc++;
        rdy = !active;
        ed = pend;
        pend = 0;
        if (active) begin
            d = cyc - t_acc;
            if (d >= TOTAL) begin
                ed = 1'b1;
                active = 0;
                ek = tgt;
            end else begin
                k = d / BT;
                if (k > 2 * BC) k = 2 * BC;
                ek = tgt ^ logic'(k[0]);
            end
        end
        if (v && rdy) begin
            if (l == ek) pend = 1;
            else begin
                active = 1;
                t_acc = cyc;
                tgt = l;
                ek = l;
            end
        end
    endtask

    task automatic check_all();
        chk("key_out", key_out, ek);
        chk("done", done, ed);
        chk("req_ready", req_ready, !active);
        chk("busy", busy, active);
    endtask

    task automatic step(input logic v, input logic l);
        @(negedge clk);
        rst = 1'b0;
        req_valid = v;
        req_level = l;
        @(posedge clk);
        model_edge(v, l);
        #1 check_all();
    endtask

    task automatic reset_now();
        rst = 1'b1;
        req_valid = 1'b0;
        active = 0;
        pend = 0;
        ek = 1'b0;
        ed = 1'b0;
        #1;
        chk("rst_key", key_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
    endtask

    initial begin
        bit hold_mode;
        int guard;
        #1 reset_now();
        step(1'b1, 1'b1);
        hold_mode = 0;
        for (int i = 0; i < 40000; i++) begin
            if (i % 500 == 0) hold_mode = $urandom_range(0, 2) == 0;
            if (hold_mode) step(1'b1, 1'($urandom));
            else step($urandom_range(0, 5) == 0, 1'($urandom));
        end
        @(negedge clk);
        #1 reset_now();
        step(1'b1, 1'b1);
        repeat (99) step(1'b0, 1'b0);
        @(posedge clk);
        model_edge(1'b0, 1'b0);
        #1 check_all();
        chk("pre_rst_key", key_out, 1'b1);
        #1 reset_now();
        step(1'b1, 1'b1);
        chk("post_rst_accept", busy, 1'b1);
        repeat (40) step(1'b0, 1'b0);
        guard = 0;
        while (!req_ready && guard < 2 * TOTAL) begin
            step(1'b0, 1'b0);
            guard++;
        end
        chk("final_idle", req_ready, 1'b1);
        step(1'b1, 1'b1);
        chk("same_level_ready", req_ready, 1'b1);
        step(1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
